// File: rtl/modmul_pkg.sv
// Shared types and helpers for the sequential modular multiplier / inverse checker.
package modmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 64;

    // Bits needed to hold a bit index 0..width-1.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/modmul_step.sv
// One interleaved shift-add step: acc_out = (2*acc_in + (b_bit ? a : 0)) mod m.
// Requires acc_in < m and a < m, so each stage stays below 2m and needs one subtract.
module modmul_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic             b_bit,
    output logic [WIDTH:0]   acc_out
);

    logic [WIDTH:0] mw;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_red;
    logic [WIDTH:0] sum;

    always_comb begin
        mw      = {1'b0, m};
        dbl     = acc_in << 1;
        dbl_red = (dbl >= mw) ? dbl - mw : dbl;
        sum     = dbl_red + (b_bit ? {1'b0, a} : '0);
        acc_out = (sum >= mw) ? sum - mw : sum;
    end

endmodule

// File: rtl/modmul_inverse_checker.sv
// Sequential (a*b) mod m with is_one flag, one bit of b per clock, valid/ready on both sides.
// Optional MODMUL_LZ_SKIP_EN starts at the most significant set bit of b to cut latency.
module modmul_inverse_checker
    import modmul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             is_one,
    output logic             err
);

    localparam int unsigned IW = idx_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   step_acc;

`ifdef MODMUL_LZ_SKIP_EN
    function automatic logic [IW-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction
`endif

    modmul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_in (acc_q),
        .a      (a_q),
        .m      (m_q),
        .b_bit  (b_q[idx_q]),
        .acc_out(step_acc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    m_d   = m;
                    acc_d = '0;
                    err_d = 1'b0;
                    if (m == '0 || a >= m || b >= m) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
`ifdef MODMUL_LZ_SKIP_EN
                        if (b == '0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = msb_index(b);
                            state_d = RUN;
                        end
`else
                        idx_d   = IW'(WIDTH - 1);
                        state_d = RUN;
`endif
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Error results keep acc at 0, so product is 0 for them without extra gating.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        product   = acc_q[WIDTH-1:0];
        is_one    = (state_q == DONE) && !err_q && (acc_q == {{WIDTH{1'b0}}, 1'b1});
        err       = err_q;
    end

endmodule

// File: tb/tb_modmul_inverse_checker.sv
// Scoreboard bench for modmul_inverse_checker (WIDTH=8); honours MODMUL_LZ_SKIP_EN for latency.
module tb_modmul_inverse_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] m_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] product;
    logic         is_one;
    logic         err;

    typedef struct {
        logic [W-1:0] product;
        logic         is_one;
        logic         err;
        int unsigned  lat;
        int unsigned  t0;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    modmul_inverse_checker #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_in),
        .b        (b_in),
        .m        (m_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .is_one   (is_one),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic. lat counts edges after the accepting edge
    // until out_valid is seen; 0 means out_valid follows the accepting edge itself.
    function automatic exp_t model(input int unsigned a, input int unsigned b,
                                   input int unsigned m, input int unsigned t0);
        exp_t e;
        e.t0 = t0;
        if (m == 0 || a >= m || b >= m) begin
            e.product = '0;
            e.is_one  = 1'b0;
            e.err     = 1'b1;
            e.lat     = 0;
        end else begin
            e.product = W'((a * b) % m);
            e.is_one  = ((a * b) % m) == 1;
            e.err     = 1'b0;
`ifdef MODMUL_LZ_SKIP_EN
            e.lat = 0;
            for (int i = 0; i < W; i++) if ((b >> i) & 1) e.lat = i + 1;
`else
            e.lat = W;
`endif
        end
        return e;
    endfunction

    // Monitor: one pop per rising out_valid.
    initial begin
        bit   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid && !seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("product", product, e.product);
                    check("is_one", is_one, e.is_one);
                    check("err", err, e.err);
                    check("latency", cyc - e.t0, e.lat);
                end
            end else if (!out_valid) begin
                seen = 0;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("idle_timeout", 0, 1);
            return;
        end
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        m_in      = m;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        e = model(a, b, m, cyc);
        sb.push_back(e);
        // Junk in_valid while busy must be ignored.
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 300) break;
            in_valid = 1'($urandom_range(0, 1));
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            m_in     = W'($urandom);
            n++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("done_timeout", 0, 1);
            out_ready = 1'b1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_product", product, e.product);
            check("hold_is_one", is_one, e.is_one);
            check("hold_err", err, e.err);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (hold > 0) begin
            check("release_valid", out_valid, 0);
            check("release_in_ready", in_ready, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_product"}, product, 0);
        check({tag, "_is_one"}, is_one, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rm;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd3, 8'd5, 8'd7, 0);
        do_op(8'd254, 8'd254, 8'd255, 0);
        do_op(8'd4, 8'd6, 8'd8, 0);
        do_op(8'd9, 8'd2, 8'd7, 0);
        do_op(8'd9, 8'd2, 8'd0, 0);
        do_op(8'd0, 8'd5, 8'd7, 0);
        do_op(8'd5, 8'd0, 8'd7, 0);
        do_op(8'd0, 8'd0, 8'd1, 0);
        do_op(8'd3, 8'd8, 8'd8, 0);
        do_op(8'd3, 8'd5, 8'd7, 5);

        // Abort mid-run, then confirm a fresh operation still works.
        @(negedge clk);
        in_valid = 1'b1;
        a_in = 8'd6;
        b_in = 8'd5;
        m_in = 8'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd2, 8'd4, 8'd7, 0);

        for (int k = 0; k < 60; k++) begin
            rm = W'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0 || rm == 0) begin
                ra = W'($urandom);
                rb = W'($urandom);
            end else begin
                ra = W'($urandom % rm);
                rb = W'($urandom % rm);
            end
            do_op(ra, rb, rm, (k % 10 == 3) ? 2 : 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
